// File: rtl/accel_pkg.sv
// ============================================================================
// Module      : accel_pkg
// Description : Shared types and defaults for the accelerator sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package accel_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WLOAD = 3'd1,
        S_ALOAD = 3'd2,
        S_MAC   = 3'd3,
        S_OLOAD = 3'd4,
        S_OOUT  = 3'd5,
        S_FIN   = 3'd6
    } seq_state_t;

    localparam logic [1:0] ACT_NONE    = 2'd0;
    localparam logic [1:0] ACT_RELU    = 2'd1;
    localparam logic [1:0] ACT_SOFTMAX = 2'd2;

    localparam int DEFAULT_ARRAY_DIM = 16;
    localparam int DEFAULT_PIPE_LAT  = 65;
    localparam int DEFAULT_OUT_LOAD  = 76;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_phase_cnt.sv
// ============================================================================
// Module      : seq_phase_cnt
// Description : Loadable down-counter; o_last flags the final cycle of a phase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_phase_cnt #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_last = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/accel_seq_ctrl.sv
// ============================================================================
// Module      : accel_seq_ctrl
// Description : Start/done tile sequencer driving tiler and accelerator enables.
//               Optional busy-cycle counter built when ACCEL_SEQ_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accel_seq_ctrl
    import accel_pkg::*;
#(
    parameter int ARRAY_DIM = DEFAULT_ARRAY_DIM,
    parameter int PIPE_LAT  = DEFAULT_PIPE_LAT,
    parameter int OUT_LOAD  = DEFAULT_OUT_LOAD,
    parameter int TILE_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [TILE_W-1:0] cfg_tiles,
    input  logic [1:0]        cfg_act_mode,
    output logic              busy,
    output logic              done,
    output logic [TILE_W-1:0] tile_idx,
    output logic              tile_w_en,
    output logic              tile_a_en,
    output logic              weight_buffer_load_en,
    output logic              input_buffer_load_en,
    output logic              write_weight_en,
    output logic              weight_buffer_out_en,
    output logic              input_buffer_out_en,
    output logic              output_buffer_load_en,
    output logic              output_buffer_out_en,
    output logic              relu_en,
    output logic              softmax_en,
    output logic [31:0]       perf_cycles
);

    localparam int CNT_W = $clog2(max3(ARRAY_DIM, PIPE_LAT, OUT_LOAD) + 1);

    localparam logic [CNT_W-1:0] C_LEN_DIM  = CNT_W'(ARRAY_DIM - 1);
    localparam logic [CNT_W-1:0] C_LEN_PIPE = CNT_W'(PIPE_LAT - 1);
    localparam logic [CNT_W-1:0] C_LEN_OUT  = CNT_W'(OUT_LOAD - 1);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic              w_cnt_load;
    logic [CNT_W-1:0]  w_cnt_val;
    logic              w_cnt_last;
    logic [TILE_W-1:0] r_tiles;
    logic [1:0]        r_mode;
    logic [TILE_W-1:0] w_tile_inc;
    logic              r_mac_oload;
    logic              w_accept;
    logic              w_kill;

    assign w_accept   = (r_state == S_IDLE) && start && !abort;
    assign w_kill     = abort && (r_state != S_IDLE);
    assign w_tile_inc = tile_idx + TILE_W'(1);

    seq_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .o_last     (w_cnt_last)
    );

    // Next-state decision; the counter reloads on every phase transition.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_load  = 1'b0;
        w_cnt_val   = C_LEN_DIM;
        if (w_kill) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (cfg_tiles != '0) begin
                            w_state_nxt = S_WLOAD;
                            w_cnt_load  = 1'b1;
                        end else begin
                            w_state_nxt = S_FIN;
                        end
                    end
                end
                S_WLOAD: begin
                    if (w_cnt_last) begin
                        w_state_nxt = S_ALOAD;
                        w_cnt_load  = 1'b1;
                    end
                end
                S_ALOAD: begin
                    if (w_cnt_last) begin
                        w_state_nxt = S_MAC;
                        w_cnt_load  = 1'b1;
                        w_cnt_val   = C_LEN_PIPE;
                    end
                end
                S_MAC: begin
                    if (w_cnt_last) begin
                        w_state_nxt = S_OLOAD;
                        w_cnt_load  = 1'b1;
                        w_cnt_val   = C_LEN_OUT;
                    end
                end
                S_OLOAD: begin
                    if (w_cnt_last) begin
                        w_state_nxt = S_OOUT;
                        w_cnt_load  = 1'b1;
                    end
                end
                S_OOUT: begin
                    if (w_cnt_last) begin
                        if (w_tile_inc == r_tiles) begin
                            w_state_nxt = S_FIN;
                        end else begin
                            w_state_nxt = S_WLOAD;
                            w_cnt_load  = 1'b1;
                        end
                    end
                end
                S_FIN:   w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Direct outputs are registered from the next state so they line up with
    // the state itself; delayed outputs are one more register behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state               <= S_IDLE;
            r_tiles               <= '0;
            r_mode                <= ACT_NONE;
            r_mac_oload           <= 1'b0;
            tile_idx              <= '0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            tile_w_en             <= 1'b0;
            tile_a_en             <= 1'b0;
            output_buffer_load_en <= 1'b0;
            output_buffer_out_en  <= 1'b0;
            relu_en               <= 1'b0;
            softmax_en            <= 1'b0;
            weight_buffer_load_en <= 1'b0;
            input_buffer_load_en  <= 1'b0;
            write_weight_en       <= 1'b0;
            weight_buffer_out_en  <= 1'b0;
            input_buffer_out_en   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_tiles <= cfg_tiles;
                r_mode  <= cfg_act_mode;
                if (cfg_tiles != '0) begin
                    tile_idx <= '0;
                end
            end else if (!w_kill && (r_state == S_OOUT) && w_cnt_last) begin
                tile_idx <= w_tile_inc;
            end

            busy                  <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_FIN);
            done                  <= (w_state_nxt == S_FIN);
            tile_w_en             <= (w_state_nxt == S_WLOAD);
            tile_a_en             <= (w_state_nxt == S_ALOAD);
            output_buffer_load_en <= (w_state_nxt == S_OLOAD);
            output_buffer_out_en  <= (w_state_nxt == S_OOUT);
            relu_en               <= (w_state_nxt == S_OOUT) && (r_mode == ACT_RELU);
            softmax_en            <= (w_state_nxt == S_OOUT) && (r_mode == ACT_SOFTMAX);
            r_mac_oload           <= (w_state_nxt == S_MAC) || (w_state_nxt == S_OLOAD);

            weight_buffer_load_en <= tile_w_en   && !w_kill;
            input_buffer_load_en  <= tile_a_en   && !w_kill;
            write_weight_en       <= tile_a_en   && !w_kill;
            weight_buffer_out_en  <= tile_a_en   && !w_kill;
            input_buffer_out_en   <= r_mac_oload && !w_kill;
        end
    end

`ifdef ACCEL_SEQ_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf <= '0;
        end else if (w_accept) begin
            r_perf <= '0;
        end else if (busy && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`else
    assign perf_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: doc/accel_seq_ctrl.md
# accel_seq_ctrl

Parametrised control sequencer for the systolic-array `accelerator`. It replaces hand-timed stimulus with a start/done FSM that drives, for each tile, the tiler enables and every `accelerator` buffer and array enable in a fixed order: weight load, activation load, matmul, output load, output drain. It loops over a run-time tile count. It sits between the host/config interface and the `accelerator` plus input/weight tiler instances.

## Interface
Parameters:
- `ARRAY_DIM`, 16: array rows/cols. Sets the length of the WLOAD, ALOAD and OOUT phases in cycles.
- `PIPE_LAT`, 65: cycles from matmul start to `output_buffer_load_en` assertion.
- `OUT_LOAD`, 76: cycles `output_buffer_load_en` stays high.
- `TILE_W`, 8: width of the tile count.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `start` in 1: single-cycle run request.
- `abort` in 1: synchronous run cancel.
- `cfg_tiles` in TILE_W: number of tiles to process. Sampled with `start`.
- `cfg_act_mode` in 2: activation select. 0 none, 1 ReLU, 2 softmax, 3 none. Sampled with `start`.
- `busy` out 1: high while a run is active.
- `done` out 1: one-cycle pulse at run completion.
- `tile_idx` out TILE_W: index of the current tile.
- `tile_w_en` out 1: weight-side tiler enable.
- `tile_a_en` out 1: activation-side tiler enable.
- `weight_buffer_load_en`, `input_buffer_load_en`, `write_weight_en`, `weight_buffer_out_en`, `input_buffer_out_en`, `output_buffer_load_en`, `output_buffer_out_en` out 1 each: `accelerator` enables.
- `relu_en`, `softmax_en` out 1 each: activation enables.
- `perf_cycles` out 32: busy-cycle counter (see Configuration).

## Operation
- FSM states: IDLE, WLOAD, ALOAD, MAC, OLOAD, OOUT, FIN.
- IDLE:
  - `start`=1 and `cfg_tiles`>0: latch the config, clear `tile_idx`, go to WLOAD.
  - `start`=1 and `cfg_tiles`=0: go to FIN. No enables assert.
- Phase lengths: WLOAD `ARRAY_DIM`, ALOAD `ARRAY_DIM`, MAC `PIPE_LAT`, OLOAD `OUT_LOAD`, OOUT `ARRAY_DIM` cycles. A single phase counter reloads on each transition.
- End of OOUT: `tile_idx`+1. If the result equals the latched `cfg_tiles`, go to FIN; otherwise go to WLOAD.
- FIN: `done`=1 for one cycle, then IDLE.
- Direct (registered-from-state) outputs:
  - `tile_w_en` = WLOAD.
  - `tile_a_en` = ALOAD.
  - `output_buffer_load_en` = OLOAD.
  - `output_buffer_out_en` = OOUT.
  - `relu_en`/`softmax_en` = OOUT qualified by the latched mode.
- Delayed outputs, one cycle behind their phase (they wait for registered tiler data):
  - `weight_buffer_load_en` follows WLOAD.
  - `input_buffer_load_en`, `write_weight_en` and `weight_buffer_out_en` follow ALOAD.
  - `input_buffer_out_en` follows MAC or OLOAD.
- `busy` = state not in IDLE/FIN.
- `start` while busy: ignored.
- `abort` (any state except IDLE): next cycle state=IDLE and all enables, including the delayed ones, are 0. No `done` pulse. `abort` beats `start` when both are high in the same cycle.

## Timing
- Reset: all outputs 0, state IDLE, `tile_idx`=0, `perf_cycles`=0.
- Cycle t0 is the cycle `start` is sampled. Per tile (first tile, default params):
  - WLOAD t0+1..t0+16.
  - ALOAD t0+17..t0+32.
  - MAC t0+33..t0+97.
  - OLOAD t0+98..t0+173.
  - OOUT t0+174..t0+189.
- Each tile takes 3·`ARRAY_DIM`+`PIPE_LAT`+`OUT_LOAD` cycles (189 at defaults). Tiles run back-to-back with no gap.
- `done` asserts at t0 + N·189 + 1.
- The delayed enable of the last cycle of a phase overlaps the first cycle of the next phase. This is intended.
- The phase counter width is `$clog2` of max(`ARRAY_DIM`,`PIPE_LAT`,`OUT_LOAD`)+1. No wrap occurs inside a phase.

## Configuration
- `ACCEL_SEQ_PERF_EN` defined: `perf_cycles` counts every cycle with `busy`=1. It clears on an accepted `start`, holds its value after `done`/`abort`, and saturates at 2^32−1.
- `ACCEL_SEQ_PERF_EN` undefined: `perf_cycles` is tied to 0 and no counter logic is built. The port list is unchanged.

## Structure
- Shared package `accel_pkg`:
  - state enum `seq_state_t`.
  - activation-mode constants `ACT_NONE`/`ACT_RELU`/`ACT_SOFTMAX`.
  - default values for `ARRAY_DIM`/`PIPE_LAT`/`OUT_LOAD`.
- One sub-module, `seq_phase_cnt`: a loadable down-counter with a `last` flag, used for all phase lengths.
- FSM, delay registers and perf counter live in the top module.

## Test plan
- Single tile, defaults: `start` at t0 with `cfg_tiles`=1. Check:
  - `tile_w_en` high t0+1..16.
  - `weight_buffer_load_en` high t0+2..17.
  - `input_buffer_out_en` high t0+34..174.
  - `output_buffer_out_en` high t0+174..189.
  - `done` pulse at t0+190.
- `cfg_tiles`=3, `cfg_act_mode`=1: `tile_idx` steps 0→1→2 at t0+190 and t0+379. `relu_en` is high only during OOUT. `done` at t0+568.
- `cfg_tiles`=0: `done` at t0+1. No enable ever asserts. `busy` stays 0.
- `abort` at t0+50 (MAC): at t0+51 all enables=0 and state is IDLE. No `done`. A following `start` runs normally.
- `start` pulsed again at t0+10: ignored, and the timing from the first start is unchanged. `rst` mid-OLOAD: all outputs 0 the next cycle.
- With `ACCEL_SEQ_PERF_EN`, one tile: `perf_cycles`=189 after `done`. Without the macro: `perf_cycles`=0 throughout.
